// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one runtime-opcode ALU among NREQ requesters.
// Optional feature: define ALU_RR_CARRY_CHAIN_EN for per-requester carry chaining (ReqChain).
module alu_rr_scheduler #(
  parameter int bits = 4,
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        ReqValid,
  output logic [NREQ-1:0]        ReqReady,
  input  logic [4*NREQ-1:0]      ReqOp,
  input  logic [bits*NREQ-1:0]   ReqA,
  input  logic [bits*NREQ-1:0]   ReqB,
  input  logic [NREQ-1:0]        ReqFlagIn,
`ifdef ALU_RR_CARRY_CHAIN_EN
  input  logic [NREQ-1:0]        ReqChain,
`endif
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic [1:0]             RspId,
  output logic [bits-1:0]        RspResult,
  output logic [3:0]             RspFlags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Returns {N,Z,C,V,result}; C on subtract-type ops is a borrow.
  function automatic logic [bits+3:0] alu_eval(
    input logic [3:0]      op,
    input logic [bits-1:0] a,
    input logic [bits-1:0] b,
    input logic            cin
  );
    logic [bits:0]   wide;
    logic [bits:0]   sh;
    logic [bits-1:0] res;
    logic [31:0]     amt;
    logic            c;
    logic            v;
    logic            n;
    logic            z;
    wide = '0;
    sh   = '0;
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    amt  = 32'(b);
    case (op)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b} + {{bits{1'b0}}, cin};
        res  = wide[bits-1:0];
        c    = wide[bits];
        v    = (a[bits-1] == b[bits-1]) && (res[bits-1] != a[bits-1]);
      end
      4'd1: begin
        wide = {1'b0, a} - {1'b0, b} - {{bits{1'b0}}, cin};
        res  = wide[bits-1:0];
        c    = wide[bits];
        v    = (a[bits-1] != b[bits-1]) && (res[bits-1] != a[bits-1]);
      end
      4'd2: begin
        wide = {1'b0, a} + {{bits{1'b0}}, 1'b1};
        res  = wide[bits-1:0];
        c    = wide[bits];
        v    = !a[bits-1] && res[bits-1];
      end
      4'd3: begin
        wide = {1'b0, a} - {{bits{1'b0}}, 1'b1};
        res  = wide[bits-1:0];
        c    = wide[bits];
        v    = a[bits-1] && !res[bits-1];
      end
      4'd4: res = a & b;
      4'd5: res = a | b;
      4'd6: res = ~a;
      4'd7: res = a ^ b;
      4'd8: begin
        if (amt >= 32'(bits)) begin
          res = '0;
        end else begin
          // The extra top bit catches the last bit shifted out.
          sh  = {1'b0, a} << amt;
          res = sh[bits-1:0];
          c   = sh[bits];
        end
      end
      4'd9: begin
        if (amt >= 32'(bits)) begin
          res = {bits{a[bits-1]}};
        end else begin
          sh  = {a, 1'b0};
          sh  = $signed(sh) >>> amt;
          res = sh[bits:1];
          c   = sh[0];
        end
      end
      default: res = '0;
    endcase
    n = res[bits-1];
    z = (res == '0);
    return {n, z, c, v, res};
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        ptr_r;
  logic [3:0]        op_r;
  logic [bits-1:0]   a_r;
  logic [bits-1:0]   b_r;
  logic              cin_r;
  logic [1:0]        id_r;

  logic              grant_any_s;
  logic [1:0]        winner_s;
  logic [3:0]        sel_op_s;
  logic [bits-1:0]   sel_a_s;
  logic [bits-1:0]   sel_b_s;
  logic              sel_cin_s;
  logic [bits+3:0]   alu_out_s;

`ifdef ALU_RR_CARRY_CHAIN_EN
  logic [NREQ-1:0]   carry_r;
`endif

  // Round-robin search starting just after the last winner.
  always_comb begin
    int  idx;
    logic hit;
    idx         = 0;
    hit         = 1'b0;
    grant_any_s = 1'b0;
    winner_s    = 2'b00;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_r) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        hit         = (idx == i) && ReqValid[i] && !grant_any_s;
        winner_s    = hit ? 2'(i) : winner_s;
        grant_any_s = grant_any_s | hit;
      end
    end
  end

  // Grant decode and winner operand mux.
  always_comb begin
    logic pick;
    pick      = 1'b0;
    ReqReady  = '0;
    sel_op_s  = 4'd0;
    sel_a_s   = '0;
    sel_b_s   = '0;
    sel_cin_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pick        = grant_any_s && (winner_s == 2'(i));
      ReqReady[i] = pick && (state_r == IDLE);
      sel_op_s    = pick ? ReqOp[4*i +: 4]       : sel_op_s;
      sel_a_s     = pick ? ReqA[bits*i +: bits]  : sel_a_s;
      sel_b_s     = pick ? ReqB[bits*i +: bits]  : sel_b_s;
`ifdef ALU_RR_CARRY_CHAIN_EN
      sel_cin_s   = pick ? (ReqChain[i] ? carry_r[i] : ReqFlagIn[i]) : sel_cin_s;
`else
      sel_cin_s   = pick ? ReqFlagIn[i] : sel_cin_s;
`endif
    end
  end

  // ALU evaluation on the latched operation.
  always_comb begin
    alu_out_s = alu_eval(op_r, a_r, b_r, cin_r);
  end

  // Scheduler FSM, operand latches and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= 2'(NREQ - 1);
      op_r      <= 4'd0;
      a_r       <= '0;
      b_r       <= '0;
      cin_r     <= 1'b0;
      id_r      <= 2'd0;
      RspValid  <= 1'b0;
      RspId     <= 2'd0;
      RspResult <= '0;
      RspFlags  <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            op_r    <= sel_op_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            cin_r   <= sel_cin_s;
            id_r    <= winner_s;
            ptr_r   <= winner_s;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          RspResult <= alu_out_s[bits-1:0];
          RspFlags  <= alu_out_s[bits+3:bits];
          RspId     <= id_r;
          RspValid  <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            state_r  <= IDLE;
          end else begin
            state_r  <= DONE;
          end
        end
        default: begin
          RspValid <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_RR_CARRY_CHAIN_EN
  // Per-requester carry, refreshed whenever that requester's add/sub completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_r <= '0;
    end else if ((state_r == EXEC) && (op_r[3:2] == 2'b00)) begin
      for (int i = 0; i < NREQ; i++) begin
        if (id_r == 2'(i)) begin
          carry_r[i] <= alu_out_s[bits+1];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler (bits=4, NREQ=2).
module tb_alu_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] ReqValid;
  logic [1:0] ReqReady;
  logic [7:0] ReqOp;
  logic [7:0] ReqA;
  logic [7:0] ReqB;
  logic [1:0] ReqFlagIn;
  logic       RspValid;
  logic       RspReady;
  logic [1:0] RspId;
  logic [3:0] RspResult;
  logic [3:0] RspFlags;
`ifdef ALU_RR_CARRY_CHAIN_EN
  logic [1:0] req_chain;
`endif

  logic       v_t  [2];
  logic [3:0] op_t [2];
  logic [3:0] a_t  [2];
  logic [3:0] b_t  [2];
  logic       f_t  [2];

  int total;
  int bad;

  assign ReqValid  = {v_t[1], v_t[0]};
  assign ReqOp     = {op_t[1], op_t[0]};
  assign ReqA      = {a_t[1], a_t[0]};
  assign ReqB      = {b_t[1], b_t[0]};
  assign ReqFlagIn = {f_t[1], f_t[0]};

  alu_rr_scheduler #(.bits(4), .NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqOp     (ReqOp),
    .ReqA      (ReqA),
    .ReqB      (ReqB),
    .ReqFlagIn (ReqFlagIn),
`ifdef ALU_RR_CARRY_CHAIN_EN
    .ReqChain  (req_chain),
`endif
    .RspValid  (RspValid),
    .RspReady  (RspReady),
    .RspId     (RspId),
    .RspResult (RspResult),
    .RspFlags  (RspFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request, waits (bounded) for its grant, returns at the negedge after the accept edge.
  task automatic issue(input logic idx, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic fin, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    v_t[idx] = 1'b1; op_t[idx] = op; a_t[idx] = a; b_t[idx] = b; f_t[idx] = fin;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (ReqReady[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    v_t[idx] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({RspValid, RspId, RspResult, RspFlags} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got %h want %h", {RspValid, RspId, RspResult, RspFlags}, 11'd0);
    end
    total++;
    if (ReqReady !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready got %b want 00", ReqReady);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    bit ok;
    issue(1'b0, 4'd0, 4'b0111, 4'b0001, 1'b0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL add_grant got timeout want grant");
    end
    total++;
    if (RspValid !== 1'b0) begin
      bad++;
      $display("FAIL add_early_valid got %b want 0", RspValid);
    end
    @(negedge clk);
    total++;
    if ({RspValid, RspId, RspResult, RspFlags} !== {1'b1, 2'd0, 4'b1000, 4'b1001}) begin
      bad++;
      $display("FAIL add_rsp got %h want %h", {RspValid, RspId, RspResult, RspFlags},
               {1'b1, 2'd0, 4'b1000, 4'b1001});
    end
  endtask

  task automatic test_sub_shift();
    bit ok;
    issue(1'b1, 4'd1, 4'b1000, 4'b1000, 1'b0, ok);
    @(negedge clk);
    total++;
    if (!ok || {RspValid, RspId, RspResult, RspFlags} !== {1'b1, 2'd1, 4'b0000, 4'b0100}) begin
      bad++;
      $display("FAIL sub_rsp got %h ok=%0d want %h", {RspValid, RspId, RspResult, RspFlags}, ok,
               {1'b1, 2'd1, 4'b0000, 4'b0100});
    end
    issue(1'b1, 4'd9, 4'b1101, 4'b0010, 1'b0, ok);
    @(negedge clk);
    total++;
    if (!ok || {RspValid, RspId, RspResult, RspFlags} !== {1'b1, 2'd1, 4'b1111, 4'b1000}) begin
      bad++;
      $display("FAIL sar_rsp got %h ok=%0d want %h", {RspValid, RspId, RspResult, RspFlags}, ok,
               {1'b1, 2'd1, 4'b1111, 4'b1000});
    end
  endtask

  task automatic test_alu_ops();
    // Hex digits per vector: op, A, B, FlagIn, result, {N,Z,C,V}
    logic [23:0] vec [16];
    bit ok;
    vec = '{24'h8510A8, 24'h8F4004, 24'h9850F8, 24'h1001FA,
            24'h380071, 24'h2F0006, 24'h6500A8, 24'h7CA060,
            24'h83308A, 24'h961030, 24'h0771F9, 24'h4CA088,
            24'h5CA0E8, 24'hFFF004, 24'h270189, 24'h132104};
    for (int k = 0; k < 16; k++) begin
      issue(1'b0, vec[k][23:20], vec[k][19:16], vec[k][15:12], vec[k][8], ok);
      @(negedge clk);
      total++;
      if (!ok || {RspValid, RspResult, RspFlags} !== {1'b1, vec[k][7:0]}) begin
        bad++;
        $display("FAIL alu_vec%0d got %h ok=%0d want %h", k, {RspValid, RspResult, RspFlags}, ok,
                 {1'b1, vec[k][7:0]});
      end
    end
  endtask

  task automatic test_round_robin();
    logic gid  [8];
    int   gcyc [8];
    int   ng;
    ng = 0;
    pulse_reset();
    RspReady = 1'b1;
    v_t[0] = 1'b1; op_t[0] = 4'd0; a_t[0] = 4'd1; b_t[0] = 4'd1; f_t[0] = 1'b0;
    v_t[1] = 1'b1; op_t[1] = 4'd2; a_t[1] = 4'd3; b_t[1] = 4'd0; f_t[1] = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      total++;
      if ($countones(ReqReady) > 1) begin
        bad++;
        $display("FAIL rr_onehot cycle %0d got %b want at most one bit", cyc, ReqReady);
      end
      if (ReqReady != 2'b00 && ng < 8) begin
        gid[ng]  = ReqReady[1];
        gcyc[ng] = cyc;
        ng++;
      end
      @(negedge clk);
    end
    v_t[0] = 1'b0;
    v_t[1] = 1'b0;
    total++;
    if (ng != 4) begin
      bad++;
      $display("FAIL rr_grant_count got %0d want 4", ng);
    end
    for (int k = 0; k < ng && k < 4; k++) begin
      total++;
      if (gid[k] !== 1'(k % 2)) begin
        bad++;
        $display("FAIL rr_order grant%0d got %0d want %0d", k, gid[k], k % 2);
      end
      if (k > 0) begin
        total++;
        if (gcyc[k] - gcyc[k-1] != 3) begin
          bad++;
          $display("FAIL rr_spacing grant%0d got %0d want 3", k, gcyc[k] - gcyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    RspReady = 1'b0;
    issue(1'b0, 4'd0, 4'b0111, 4'b0001, 1'b0, ok);
    v_t[1] = 1'b1; op_t[1] = 4'd4; a_t[1] = 4'hC; b_t[1] = 4'hA; f_t[1] = 1'b0;
    #1;
    total++;
    if (!ok || ReqReady !== 2'b00) begin
      bad++;
      $display("FAIL bp_exec_ready got %b ok=%0d want 00", ReqReady, ok);
    end
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      total++;
      if ({RspValid, RspId, RspResult, RspFlags, ReqReady} !== {1'b1, 2'd0, 4'b1000, 4'b1001, 2'b00}) begin
        bad++;
        $display("FAIL bp_hold cycle %0d got %h want %h", n, {RspValid, RspId, RspResult, RspFlags, ReqReady},
                 {1'b1, 2'd0, 4'b1000, 4'b1001, 2'b00});
      end
      @(negedge clk);
    end
    RspReady = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({RspValid, ReqReady} !== {1'b0, 2'b10}) begin
      bad++;
      $display("FAIL bp_resume got %b want 010", {RspValid, ReqReady});
    end
    @(posedge clk);
    @(negedge clk);
    v_t[1] = 1'b0;
    @(negedge clk);
    total++;
    if ({RspValid, RspId, RspResult, RspFlags} !== {1'b1, 2'd1, 4'b1000, 4'b1000}) begin
      bad++;
      $display("FAIL bp_second_rsp got %h want %h", {RspValid, RspId, RspResult, RspFlags},
               {1'b1, 2'd1, 4'b1000, 4'b1000});
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    issue(1'b1, 4'd0, 4'b0001, 4'b0001, 1'b0, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (!ok || {RspValid, ReqReady} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle got %b ok=%0d want 000", {RspValid, ReqReady}, ok);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (RspValid !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_rsp cycle %0d got %b want 0", n, RspValid);
      end
    end
    v_t[0] = 1'b1; op_t[0] = 4'hA; a_t[0] = 4'hF; b_t[0] = 4'hF; f_t[0] = 1'b1;
    v_t[1] = 1'b1; op_t[1] = 4'd0; a_t[1] = 4'd2; b_t[1] = 4'd2; f_t[1] = 1'b0;
    #1;
    total++;
    if (ReqReady !== 2'b01) begin
      bad++;
      $display("FAIL abort_first_grant got %b want 01", ReqReady);
    end
    @(posedge clk);
    @(negedge clk);
    v_t[0] = 1'b0;
    v_t[1] = 1'b0;
    @(negedge clk);
    total++;
    if ({RspValid, RspId, RspResult, RspFlags} !== {1'b1, 2'd0, 4'b0000, 4'b0100}) begin
      bad++;
      $display("FAIL illegal_op_rsp got %h want %h", {RspValid, RspId, RspResult, RspFlags},
               {1'b1, 2'd0, 4'b0000, 4'b0100});
    end
  endtask

`ifdef ALU_RR_CARRY_CHAIN_EN
  task automatic test_carry_chain();
    bit ok;
    pulse_reset();
    req_chain = 2'b00;
    issue(1'b0, 4'd0, 4'b1111, 4'b0001, 1'b0, ok);
    @(negedge clk);
    total++;
    if (!ok || {RspValid, RspId, RspResult, RspFlags} !== {1'b1, 2'd0, 4'b0000, 4'b0110}) begin
      bad++;
      $display("FAIL chain_low got %h ok=%0d want %h", {RspValid, RspId, RspResult, RspFlags}, ok,
               {1'b1, 2'd0, 4'b0000, 4'b0110});
    end
    issue(1'b1, 4'd0, 4'b0001, 4'b0001, 1'b0, ok);
    @(negedge clk);
    total++;
    if (!ok || {RspValid, RspId, RspResult, RspFlags} !== {1'b1, 2'd1, 4'b0010, 4'b0000}) begin
      bad++;
      $display("FAIL chain_other got %h ok=%0d want %h", {RspValid, RspId, RspResult, RspFlags}, ok,
               {1'b1, 2'd1, 4'b0010, 4'b0000});
    end
    req_chain = 2'b01;
    issue(1'b0, 4'd0, 4'b0000, 4'b0000, 1'b0, ok);
    req_chain = 2'b00;
    @(negedge clk);
    total++;
    if (!ok || {RspValid, RspId, RspResult, RspFlags} !== {1'b1, 2'd0, 4'b0001, 4'b0000}) begin
      bad++;
      $display("FAIL chain_high got %h ok=%0d want %h", {RspValid, RspId, RspResult, RspFlags}, ok,
               {1'b1, 2'd0, 4'b0001, 4'b0000});
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    RspReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v_t[i] = 1'b0; op_t[i] = 4'd0; a_t[i] = 4'd0; b_t[i] = 4'd0; f_t[i] = 1'b0;
    end
`ifdef ALU_RR_CARRY_CHAIN_EN
    req_chain = 2'b00;
`endif
    test_reset();
    test_add();
    test_sub_shift();
    test_alu_ops();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
`ifdef ALU_RR_CARRY_CHAIN_EN
    test_carry_chain();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
